// File: rtl/rgb_colour_pkg.sv
// -----------------------------------------------------------------------------
// rgb_colour_pkg
// Shared definitions for the RGB colour-cycling LED blocks.
//   - 3-bit line codes {red, green, blue} for the six legal colours
//   - colour index enum (0..5 legal, 7 = invalid)
//   - colour_succ(): next colour in the RED->...->MAGENTA->RED cycle
//   - monitor FSM state enum
// -----------------------------------------------------------------------------
package rgb_colour_pkg;

    // Line codes, bit order {red, green, blue}
    localparam logic [2:0] CODE_RED     = 3'b100;
    localparam logic [2:0] CODE_YELLOW  = 3'b110;
    localparam logic [2:0] CODE_GREEN   = 3'b010;
    localparam logic [2:0] CODE_CYAN    = 3'b011;
    localparam logic [2:0] CODE_BLUE    = 3'b001;
    localparam logic [2:0] CODE_MAGENTA = 3'b101;

    typedef enum logic [2:0] {
        IDX_RED     = 3'd0,
        IDX_YELLOW  = 3'd1,
        IDX_GREEN   = 3'd2,
        IDX_CYAN    = 3'd3,
        IDX_BLUE    = 3'd4,
        IDX_MAGENTA = 3'd5,
        IDX_INVALID = 3'd7
    } colour_idx_e;

    typedef enum logic [1:0] {
        MON_UNLOCKED = 2'd0,
        MON_ACQUIRE  = 2'd1,
        MON_LOCKED   = 2'd2
    } mon_state_e;

    // Successor in the colour cycle; MAGENTA wraps back to RED.
    // Only meaningful for legal indices 0..5.
    function automatic logic [2:0] colour_succ(input logic [2:0] idx);
        if (idx == 3'(IDX_MAGENTA)) begin
            return 3'(IDX_RED);
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rgb_colour_decode.sv
// -----------------------------------------------------------------------------
// rgb_colour_decode
// Purely combinational decode of a {red, green, blue} line code to a colour
// index. 000 and 111 are not part of the cycle and decode to IDX_INVALID.
// Ports:
//   rgb_i    [2:0] line code {red, green, blue}
//   idx_o    [2:0] colour index 0..5, or 7 when invalid
//   valid_o        idx_o holds a legal colour
// -----------------------------------------------------------------------------
module rgb_colour_decode
    import rgb_colour_pkg::*;
(
    input  logic [2:0] rgb_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 3'(IDX_INVALID);
        valid_o = 1'b0;
        case (rgb_i)
            CODE_RED:     begin idx_o = 3'(IDX_RED);     valid_o = 1'b1; end
            CODE_YELLOW:  begin idx_o = 3'(IDX_YELLOW);  valid_o = 1'b1; end
            CODE_GREEN:   begin idx_o = 3'(IDX_GREEN);   valid_o = 1'b1; end
            CODE_CYAN:    begin idx_o = 3'(IDX_CYAN);    valid_o = 1'b1; end
            CODE_BLUE:    begin idx_o = 3'(IDX_BLUE);    valid_o = 1'b1; end
            CODE_MAGENTA: begin idx_o = 3'(IDX_MAGENTA); valid_o = 1'b1; end
            default:      begin idx_o = 3'(IDX_INVALID); valid_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/rgb_sequence_monitor.sv
// -----------------------------------------------------------------------------
// rgb_sequence_monitor
// Watches the red/green/blue LED lines, decodes the colour, measures how long
// each colour is held and checks both the colour order and the dwell time.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   red, green, blue    LED lines from the colour-cycle driver
//   colour_idx   [2:0]  decoded colour (0..5, 7 = invalid)
//   colour_valid        colour_idx is a legal colour
//   locked              order and timing verified (state == LOCKED)
//   seq_error           1-cycle pulse: order violation / invalid code while locked
//   timing_error        1-cycle pulse: dwell out of range / stuck colour while locked
//   last_dwell          dwell of the previous colour in cycles
//   error_count         saturating count of error events
//   state_dbg    [1:0]  current monitor FSM state (debug)
// All outputs are registered; an input edge reaches colour_idx and the error
// pulses two cycles later (input register, then output register).
// -----------------------------------------------------------------------------
module rgb_sequence_monitor
    import rgb_colour_pkg::*;
#(
    parameter int STATE_INTERVAL = 2000000,
    parameter int TOLERANCE      = 2,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         red,
    input  logic                                         green,
    input  logic                                         blue,
    output logic [2:0]                                   colour_idx,
    output logic                                         colour_valid,
    output logic                                         locked,
    output logic                                         seq_error,
    output logic                                         timing_error,
    output logic [$clog2(STATE_INTERVAL+TOLERANCE+2)-1:0] last_dwell,
    output logic [ERR_CNT_W-1:0]                         error_count,
    output logic [1:0]                                   state_dbg
);

    localparam int CW = $clog2(STATE_INTERVAL + TOLERANCE + 2);

    // The counter stops one past the upper tolerance bound, so a saturated
    // value is always out of range and doubles as the stuck-colour marker.
    localparam logic [CW-1:0] DWELL_SAT = CW'(STATE_INTERVAL + TOLERANCE + 1);
    localparam logic [CW-1:0] DWELL_LO  = CW'(STATE_INTERVAL - TOLERANCE);
    localparam logic [CW-1:0] DWELL_HI  = CW'(STATE_INTERVAL + TOLERANCE);

    localparam logic [1:0] S_UNLOCKED = MON_UNLOCKED;
    localparam logic [1:0] S_ACQUIRE  = MON_ACQUIRE;
    localparam logic [1:0] S_LOCKED   = MON_LOCKED;

    logic [2:0]           rgb_q,        rgb_prev_q;
    logic [CW-1:0]        cnt_q,        cnt_d;
    logic [1:0]           state_q,      state_d;
    logic [2:0]           colour_idx_q;
    logic                 colour_valid_q;
    logic                 locked_q;
    logic                 seq_err_q,    seq_err_d;
    logic                 tim_err_q,    tim_err_d;
    logic [CW-1:0]        last_dwell_q, last_dwell_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

    logic [2:0] new_idx, old_idx;
    logic       new_valid, old_valid;
    logic       change, in_range, stuck;

    // New colour (stage 1) and the colour it replaced (stage 2)
    rgb_colour_decode u_dec_new (
        .rgb_i   (rgb_q),
        .idx_o   (new_idx),
        .valid_o (new_valid)
    );

    rgb_colour_decode u_dec_old (
        .rgb_i   (rgb_prev_q),
        .idx_o   (old_idx),
        .valid_o (old_valid)
    );

    always_comb begin
        change   = (rgb_q != rgb_prev_q);
        // cnt_q is the dwell of the outgoing colour at the change cycle
        in_range = (cnt_q >= DWELL_LO) && (cnt_q <= DWELL_HI);
        stuck    = !change && (cnt_q == DWELL_SAT);

        if (change) begin
            cnt_d = CW'(1);
        end else if (cnt_q == DWELL_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        last_dwell_d = change ? cnt_q : last_dwell_q;

        state_d   = state_q;
        seq_err_d = 1'b0;
        tim_err_d = 1'b0;

        case (state_q)
            S_UNLOCKED: begin
                if (change && new_valid) begin
                    state_d = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                // Errors are not reported while acquiring; only lock or drop.
                if (change) begin
                    if (!new_valid) begin
                        state_d = S_UNLOCKED;
                    end else if (old_valid && (new_idx == colour_succ(old_idx)) && in_range) begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                // The change path takes priority over the stuck check, so a
                // change arriving on a saturated count is judged once, as a
                // dwell of DWELL_SAT.
                if (change) begin
                    if (!new_valid) begin
                        seq_err_d = 1'b1;
                        state_d   = S_UNLOCKED;
                    end else begin
                        seq_err_d = (new_idx != colour_succ(old_idx));
                        tim_err_d = !in_range;
                        if (seq_err_d || tim_err_d) begin
                            state_d = S_ACQUIRE;
                        end
                    end
                end else if (stuck) begin
                    tim_err_d = 1'b1;
                    state_d   = S_UNLOCKED;
                end
            end
            default: state_d = S_UNLOCKED;
        endcase

        // One event per change even when both pulses fire
        err_cnt_d = err_cnt_q;
        if ((seq_err_d || tim_err_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q          <= 3'b000;
            rgb_prev_q     <= 3'b000;
            cnt_q          <= '0;
            state_q        <= S_UNLOCKED;
            colour_idx_q   <= 3'(IDX_INVALID);
            colour_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            seq_err_q      <= 1'b0;
            tim_err_q      <= 1'b0;
            last_dwell_q   <= '0;
            err_cnt_q      <= '0;
        end else begin
            rgb_q          <= {red, green, blue};
            rgb_prev_q     <= rgb_q;
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            colour_idx_q   <= new_idx;
            colour_valid_q <= new_valid;
            locked_q       <= (state_d == S_LOCKED);
            seq_err_q      <= seq_err_d;
            tim_err_q      <= tim_err_d;
            last_dwell_q   <= last_dwell_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign colour_idx   = colour_idx_q;
    assign colour_valid = colour_valid_q;
    assign locked       = locked_q;
    assign seq_error    = seq_err_q;
    assign timing_error = tim_err_q;
    assign last_dwell   = last_dwell_q;
    assign error_count  = err_cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_rgb_sequence_monitor.sv
module tb_rgb_sequence_monitor;

    localparam logic [2:0] R = 3'b100, Y = 3'b110, G = 3'b010;
    localparam logic [2:0] C = 3'b011, B = 3'b001, M = 3'b101;
    localparam logic [1:0] ST_U = 2'd0, ST_A = 2'd1, ST_L = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic red = 1'b0, green = 1'b0, blue = 1'b0;

    always #5 clk = ~clk;

    logic [2:0] colour_idx;
    logic       colour_valid, locked, seq_error, timing_error;
    logic [3:0] last_dwell;
    logic [3:0] error_count;
    logic [1:0] state_dbg;

    rgb_sequence_monitor #(
        .STATE_INTERVAL (8),
        .TOLERANCE      (1),
        .ERR_CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .colour_idx   (colour_idx),
        .colour_valid (colour_valid),
        .locked       (locked),
        .seq_error    (seq_error),
        .timing_error (timing_error),
        .last_dwell   (last_dwell),
        .error_count  (error_count),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One segment = drive a code and hold it; expectations are for the
    // second cycle after the drive, plus state at the end of the hold.
    typedef struct {
        logic [2:0] code;
        logic [2:0] idx;
        int         hold;
        logic       lock;
        logic       seq;
        logic       tim;
        int         dwell;
        int         err;
        logic [1:0] st;
        int         stuck;
    } seg_t;

    seg_t vec[$];

    task automatic add(input logic [2:0] code, input logic [2:0] idx, input int hold,
                       input logic lock, input logic seq, input logic tim,
                       input int dwell, input int err, input logic [1:0] st,
                       input int stuck);
        seg_t s;
        s.code = code; s.idx = idx; s.hold = hold; s.lock = lock; s.seq = seq;
        s.tim = tim; s.dwell = dwell; s.err = err; s.st = st; s.stuck = stuck;
        vec.push_back(s);
    endtask

    // ---------------- driver ----------------
    task automatic apply_seg(input seg_t s);
        {red, green, blue} = s.code;
        for (int c = 1; c <= s.hold; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                check("colour_idx",   colour_idx,   s.idx);
                check("colour_valid", colour_valid, (s.idx != 3'd7) ? 1 : 0);
                check("locked",       locked,       s.lock);
                check("seq_error",    seq_error,    s.seq);
                check("timing_error", timing_error, s.tim);
                check("last_dwell",   last_dwell,   s.dwell);
                check("error_count",  error_count,  s.err);
            end else begin
                check("seq_error_idle",    seq_error,    0);
                check("timing_error_idle", timing_error, (c == s.stuck) ? 1 : 0);
            end
        end
        check("state_end",  state_dbg, s.st);
        check("locked_end", locked,    (s.st == ST_L) ? 1 : 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_colour_idx"},   colour_idx,   7);
        check({tag, "_colour_valid"}, colour_valid, 0);
        check({tag, "_locked"},       locked,       0);
        check({tag, "_seq_error"},    seq_error,    0);
        check({tag, "_timing_error"}, timing_error, 0);
        check({tag, "_last_dwell"},   last_dwell,   0);
        check({tag, "_error_count"},  error_count,  0);
        check({tag, "_state"},        state_dbg,    ST_U);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        logic [2:0] cyc [6];
        int e;
        cyc[0] = R; cyc[1] = Y; cyc[2] = G; cyc[3] = C; cyc[4] = B; cyc[5] = M;

        // Clean cycle: rest of round 1 (RED is driven by hand), then 2 rounds
        for (int i = 1; i < 6; i++) add(cyc[i], 3'(i), 8, 1, 0, 0, 8, 0, ST_L, 0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 6; i++) add(cyc[i], 3'(i), 8, 1, 0, 0, 8, 0, ST_L, 0);
        // Skip GREEN, then recover
        add(R, 0, 8, 1, 0, 0, 8, 0, ST_L, 0);
        add(Y, 1, 8, 1, 0, 0, 8, 0, ST_L, 0);
        add(C, 3, 8, 0, 1, 0, 8, 1, ST_A, 0);
        add(B, 4, 8, 1, 0, 0, 8, 1, ST_L, 0);
        add(M, 5, 8, 1, 0, 0, 8, 1, ST_L, 0);
        // Short dwell, then stuck colour while locked
        add(R, 0, 8, 1, 0, 0, 8, 1, ST_L, 0);
        add(Y, 1, 8, 1, 0, 0, 8, 1, ST_L, 0);
        add(G, 2, 6, 1, 0, 0, 8, 1, ST_L, 0);
        add(C, 3, 8, 0, 0, 1, 6, 2, ST_A, 0);
        add(B, 4, 8, 1, 0, 0, 8, 2, ST_L, 0);
        add(M, 5, 14, 1, 0, 0, 8, 2, ST_U, 12);
        add(R, 0, 8, 0, 0, 0, 10, 3, ST_A, 0);
        add(Y, 1, 8, 1, 0, 0, 8, 3, ST_L, 0);
        // Tolerance edges, invalid codes
        add(G, 2, 9, 1, 0, 0, 8, 3, ST_L, 0);
        add(C, 3, 7, 1, 0, 0, 9, 3, ST_L, 0);
        add(B, 4, 8, 1, 0, 0, 7, 3, ST_L, 0);
        add(3'b000, 7, 8, 0, 1, 0, 8, 4, ST_U, 0);
        add(R, 0, 8, 0, 0, 0, 8, 4, ST_A, 0);
        add(Y, 1, 8, 1, 0, 0, 8, 4, ST_L, 0);
        add(G, 2, 5, 1, 0, 0, 8, 4, ST_L, 0);
        add(C, 3, 8, 0, 0, 1, 5, 5, ST_A, 0);
        add(3'b111, 7, 8, 0, 0, 0, 8, 5, ST_U, 0);
        add(B, 4, 8, 0, 0, 0, 8, 5, ST_A, 0);
        add(M, 5, 8, 1, 0, 0, 8, 5, ST_L, 0);
        // Change on a saturated count; seq+timing on one change
        add(R, 0, 10, 1, 0, 0, 8, 5, ST_L, 0);
        add(Y, 1, 8, 0, 0, 1, 10, 6, ST_A, 0);
        add(G, 2, 4, 1, 0, 0, 8, 6, ST_L, 0);
        add(M, 5, 8, 0, 1, 1, 4, 7, ST_A, 0);
        // 20 more error events: error_count must stop at 15
        e = 7;
        for (int i = 0; i < 20; i++) begin
            add(R, 0, 8, (i == 0), 0, 0, 8, e, (i == 0) ? ST_L : ST_A, 0);
            add(Y, 1, 8, 1, 0, 0, 8, e, ST_L, 0);
            e = (e < 15) ? e + 1 : 15;
            add(B, 4, 8, 0, 1, 0, 8, e, ST_A, 0);
        end

        // Reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            {red, green, blue} = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        check_reset_values("reset_hold");

        // Release with RED driven: invalid for one more cycle, RED after two
        rst_n = 1'b1;
        {red, green, blue} = R;
        @(posedge clk); #1;
        check("rel1_colour_idx",   colour_idx,   7);
        check("rel1_colour_valid", colour_valid, 0);
        @(posedge clk); #1;
        check("rel2_colour_idx",   colour_idx,   0);
        check("rel2_colour_valid", colour_valid, 1);
        check("rel2_last_dwell",   last_dwell,   1);
        check("rel2_locked",       locked,       0);
        check("rel2_state",        state_dbg,    ST_A);
        repeat (6) @(posedge clk);
        #1;

        foreach (vec[i]) apply_seg(vec[i]);

        // Asynchronous reset in ACQUIRE, between clock edges
        {red, green, blue} = R;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_state",       state_dbg,   ST_A);
        check("pre_reset_error_count", error_count, 15);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel3_colour_idx", colour_idx, 7);
        @(posedge clk); #1;
        check("rel4_colour_idx", colour_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rgb_sequence_monitor.md
Name: rgb_sequence_monitor

Overview:
- Receiving end of the RGB colour-cycling LED interface: samples the red/green/blue lines driven by the colour-cycle FSM and decodes them to a colour index.
- Measures how long each colour is held and checks the RED→YELLOW→GREEN→CYAN→BLUE→MAGENTA→RED order and the dwell time.
- Reports lock status, error pulses and a saturating error count.
- Sits beside the LED driver on the same clock, as a self-check and debug monitor.

Parameters:
- STATE_INTERVAL, 2000000, expected dwell per colour in clk cycles (12 MHz clock).
- TOLERANCE, 2, allowed ± deviation in dwell cycles; must satisfy TOLERANCE < STATE_INTERVAL.
- ERR_CNT_W, 16, width of error_count.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- red  input  1  red LED line.
- green  input  1  green LED line.
- blue  input  1  blue LED line.
- colour_idx  output  3  decoded colour: 0=RED, 1=YELLOW, 2=GREEN, 3=CYAN, 4=BLUE, 5=MAGENTA, 7=invalid.
- colour_valid  output  1  colour_idx is 0..5.
- locked  output  1  sequence and timing verified.
- seq_error  output  1  one-cycle pulse: order violation or invalid code.
- timing_error  output  1  one-cycle pulse: dwell out of range, or stuck colour.
- last_dwell  output  CW  dwell of the previous colour in cycles; CW = $clog2(STATE_INTERVAL+TOLERANCE+2).
- error_count  output  ERR_CNT_W  saturating count of error events.

Behaviour:
- Reset (async assert, sync release): all internal registers clear; FSM=UNLOCKED.
  - Output reset values: colour_idx=7, colour_valid=0, locked=0, seq_error=0, timing_error=0, last_dwell=0, error_count=0.
- Pipeline:
  - Stage 1: {red,green,blue} registered into rgb_q.
  - Stage 2: rgb_prev <= rgb_q.
  - change = (rgb_q != rgb_prev).
  - All outputs are registered. Latency from an input edge to colour_idx / error pulses is 2 cycles.
- Decode:
  - 100→0, 110→1, 010→2, 011→3, 001→4, 101→5.
  - 000 and 111 decode to 7 (invalid).
- Dwell counter:
  - On change, loads 1 and captures the old count into last_dwell.
  - Otherwise increments, saturating at STATE_INTERVAL+TOLERANCE+1.
- In range means STATE_INTERVAL-TOLERANCE <= dwell <= STATE_INTERVAL+TOLERANCE.
- FSM states and transitions:
  - UNLOCKED: on change to a valid colour → ACQUIRE. No checks are made in this state.
  - ACQUIRE: on change, if new = successor(old) and dwell is in range → LOCKED; otherwise → ACQUIRE with no error pulse.
  - LOCKED, change to a valid colour:
    - Non-successor → seq_error pulse.
    - Dwell out of range → timing_error pulse.
    - Any error → ACQUIRE.
  - LOCKED, change to an invalid colour → seq_error pulse, → UNLOCKED.
  - LOCKED, counter saturates with no change (stuck colour) → timing_error pulse, → UNLOCKED.
  - An invalid colour in ACQUIRE → UNLOCKED with no pulse.
  - locked = (state == LOCKED), registered.
- Simultaneous events:
  - Change on the same cycle as saturation: the change path wins and gives a single timing evaluation (dwell = max → timing_error).
  - seq_error and timing_error on the same change: both pulse, and error_count increments by 1 only.
- error_count: +1 per error event while not saturated; holds at all-ones.
- Wrap-around: MAGENTA→RED is a legal successor.
- Reset mid-operation: immediate clear, regardless of pipeline contents.

Decomposition:
- Package rgb_colour_pkg contains:
  - the 3-bit colour code localparams (RED..MAGENTA);
  - the colour index enum;
  - a successor function over the index (5→0);
  - the monitor state enum {UNLOCKED, ACQUIRE, LOCKED}.
- Sub-module rgb_colour_decode: combinational code→{idx, valid}. It is reused by future LED blocks.

Test Plan:
All tests use STATE_INTERVAL=8, TOLERANCE=1, ERR_CNT_W=4.
1. Hold rst_n=0, toggle inputs, then release → all outputs at reset values, colour_idx=7; first valid colour appears 2 cycles after release.
2. Drive the clean cycle RED..MAGENTA at 8 cycles/colour for 3 full rounds → locked=1 from 2 cycles after the second change onward; no error pulses; last_dwell=8; MAGENTA→RED accepted.
3. While locked, drive YELLOW→CYAN (skip GREEN) → seq_error one pulse, error_count=1, locked=0; then 2 correct transitions → locked=1.
4. While locked, hold GREEN for 6 cycles → timing_error pulse at the change, last_dwell=6; hold the next colour for 12 cycles → timing_error when the count hits 10, state UNLOCKED, locked=0.
5. While locked, drive 000 → seq_error, colour_valid=0, colour_idx=7, UNLOCKED. Dwell 9 and dwell 7 are accepted with no errors.
6. Inject 20 error events → error_count saturates at 15. Assert rst_n mid-ACQUIRE → outputs clear in the same cycle, asynchronously.
